// File: rtl/vga_timing_gen_if.sv
// Pixel-side and VGA-pin signal bundle for vga_timing_gen.
// master: the timing generator. slave: the renderer/board side.
interface vga_timing_gen_if;
  logic [2:0]  PIXEL;
  logic [10:0] PIXEL_H;
  logic [10:0] PIXEL_V;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_R;
  logic        VGA_G;
  logic        VGA_B;
  logic        VISIBLE;
  logic        FRAME_START;

  modport master (
    input  PIXEL,
    output PIXEL_H, PIXEL_V,
    output VGA_HS, VGA_VS,
    output VGA_R, VGA_G, VGA_B,
    output VISIBLE, FRAME_START
  );

  modport slave (
    output PIXEL,
    input  PIXEL_H, PIXEL_V,
    input  VGA_HS, VGA_VS,
    input  VGA_R, VGA_G, VGA_B,
    input  VISIBLE, FRAME_START
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Drives pixel coordinates to a renderer and
// takes its colour back after PIXEL_LATENCY clocks. Blanking and syncs are
// delayed by the same amount so that everything reaches the pins together.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE     = 800,
  parameter int unsigned H_FRONT       = 56,
  parameter int unsigned H_SYNC        = 120,
  parameter int unsigned H_BACK        = 64,
  parameter int unsigned V_VISIBLE     = 600,
  parameter int unsigned V_FRONT       = 37,
  parameter int unsigned V_SYNC        = 6,
  parameter int unsigned V_BACK        = 23,
  parameter logic        HS_POL        = 1'b1,
  parameter logic        VS_POL        = 1'b1,
  parameter int unsigned PIXEL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Decode limits are kept 12 bits wide so a total of exactly 2048 still
  // compares correctly against the 11-bit counters.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] H_HS_ON  = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] H_HS_OFF = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_VS_ON  = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] V_VS_OFF = 12'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 2048) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 2048");
  end
  if (PIXEL_LATENCY > 7) begin : g_latency_check
    $error("vga_timing_gen: PIXEL_LATENCY must be 0..7");
  end

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } ctl_t;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        h_last;
  logic        v_last;
  ctl_t        ctl_raw;
  ctl_t        ctl_dly;

  logic        hs_q;
  logic        vs_q;
  logic        vis_q;
  logic [2:0]  rgb_q;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);

  // Raster counters: horizontal every clock, vertical on each line wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Undelayed active/sync decode; vs only moves with v_cnt, i.e. at h_cnt=0.
  always_comb begin
    ctl_raw        = '0;
    ctl_raw.active = (h_ext < H_VIS) && (v_ext < V_VIS);
    ctl_raw.hs     = (h_ext >= H_HS_ON) && (h_ext < H_HS_OFF);
    ctl_raw.vs     = (v_ext >= V_VS_ON) && (v_ext < V_VS_OFF);
  end

  if (PIXEL_LATENCY == 0) begin : g_no_delay
    assign ctl_dly = ctl_raw;
  end else begin : g_delay
    ctl_t pipe [PIXEL_LATENCY];

    // Match the renderer latency; cleared on reset so an aborted sync
    // pulse cannot leak out after release.
    always_ff @(posedge clk) begin
      if (reset) begin
        pipe <= '{default: '0};
      end else begin
        pipe[0] <= ctl_raw;
        for (int unsigned i = 1; i < PIXEL_LATENCY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign ctl_dly = pipe[PIXEL_LATENCY-1];
  end

  // Output register: polarity-adjusted syncs and blanked colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      vis_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= ctl_dly.hs ? HS_POL : ~HS_POL;
      vs_q  <= ctl_dly.vs ? VS_POL : ~VS_POL;
      vis_q <= ctl_dly.active;
      rgb_q <= ctl_dly.active ? vga.PIXEL : 3'b000;
    end
  end

  assign vga.PIXEL_H     = h_cnt;
  assign vga.PIXEL_V     = v_cnt;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VISIBLE     = vis_q;
  assign vga.VGA_R       = rgb_q[2];
  assign vga.VGA_G       = rgb_q[1];
  assign vga.VGA_B       = rgb_q[0];
  assign vga.FRAME_START = (h_cnt == '0) && (v_cnt == '0) && !reset;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster. Expected outputs come from
// an elapsed-time model: coordinates are time modulo the line/frame totals,
// and every pin reflects the coordinate PIXEL_LATENCY+1 clocks earlier.
module tb_vga_timing_gen;

  localparam int HV  = 16;
  localparam int HF  = 3;
  localparam int HSY = 5;
  localparam int HB  = 4;
  localparam int VV  = 10;
  localparam int VF  = 2;
  localparam int VSY = 3;
  localparam int VB  = 2;
  localparam int LAT = 2;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int FR  = HT * VT;
  localparam int D   = LAT + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .H_VISIBLE    (HV),
    .H_FRONT      (HF),
    .H_SYNC       (HSY),
    .H_BACK       (HB),
    .V_VISIBLE    (VV),
    .V_FRONT      (VF),
    .V_SYNC       (VSY),
    .V_BACK       (VB),
    .HS_POL       (HSP),
    .VS_POL       (VSP),
    .PIXEL_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vga)
  );

  int          checks = 0;
  int          errors = 0;
  int          tm     = -1;   // time since release; -1 while in reset
  int          cyc    = 0;
  int unsigned seed;
  logic [21:0] hist [$];
  bit          exp_hs_on;
  bit          exp_vs_on;
  bit          measure;
  int          vis_cnt, hs_cnt, vs_cnt;
  int          fs_first, fs_second;

  function automatic logic [2:0] colour(input int h, input int v);
    return 3'((h * 5 + v * 3 + int'(seed & 32'h7)) & 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (tm=%0d)", tag, obs, exp, tm);
    end
  endtask

  task automatic check_model();
    int  h, v, dh, dv;
    bit  vis, hs, vs;
    logic [2:0] rgb;
    rgb = {vga.VGA_R, vga.VGA_G, vga.VGA_B};
    exp_hs_on = 1'b0;
    exp_vs_on = 1'b0;
    if (tm < 0) begin
      check("rst_h",   32'(vga.PIXEL_H), 0);
      check("rst_v",   32'(vga.PIXEL_V), 0);
      check("rst_fs",  32'(vga.FRAME_START), 0);
      check("rst_hs",  32'(vga.VGA_HS), 32'(!HSP));
      check("rst_vs",  32'(vga.VGA_VS), 32'(!VSP));
      check("rst_vis", 32'(vga.VISIBLE), 0);
      check("rst_rgb", 32'(rgb), 0);
    end else begin
      h = tm % HT;
      v = (tm / HT) % VT;
      check("pixel_h", 32'(vga.PIXEL_H), 32'(h));
      check("pixel_v", 32'(vga.PIXEL_V), 32'(v));
      check("frame_start", 32'(vga.FRAME_START), 32'(h == 0 && v == 0));
      if (tm >= D) begin
        dh  = (tm - D) % HT;
        dv  = ((tm - D) / HT) % VT;
        vis = (dh < HV) && (dv < VV);
        hs  = (dh >= HV + HF) && (dh < HV + HF + HSY);
        vs  = (dv >= VV + VF) && (dv < VV + VF + VSY);
      end else begin
        dh = 0; dv = 0; vis = 0; hs = 0; vs = 0;
      end
      exp_hs_on = hs;
      exp_vs_on = vs;
      check("vga_hs",  32'(vga.VGA_HS), 32'(hs ? HSP : !HSP));
      check("vga_vs",  32'(vga.VGA_VS), 32'(vs ? VSP : !VSP));
      check("visible", 32'(vga.VISIBLE), 32'(vis));
      check("rgb",     32'(rgb), 32'(vis ? colour(dh, dv) : 3'b000));
    end
  endtask

  // One clock: check after the edge, act as a LAT-deep renderer, then set
  // reset for the following edge.
  task automatic cycle(input logic rst_next);
    logic [21:0] c;
    @(negedge clk);
    cyc++;
    if (tm >= 0) tm++;
    check_model();
    if (measure && tm >= D && tm < D + FR) begin
      if (vga.VISIBLE === 1'b1) vis_cnt++;
      if (vga.VGA_HS === HSP)   hs_cnt++;
      if (vga.VGA_VS === VSP)   vs_cnt++;
    end
    if (measure && tm > 0 && vga.FRAME_START === 1'b1) begin
      if (fs_first < 0) fs_first = cyc;
      else if (fs_second < 0) fs_second = cyc;
    end
    hist.push_back({vga.PIXEL_H, vga.PIXEL_V});
    if (hist.size() > 8) void'(hist.pop_front());
    if (hist.size() > LAT) begin
      c = hist[hist.size() - 1 - LAT];
      vga.PIXEL = colour(int'(c[21:11]), int'(c[10:0]));
    end else begin
      vga.PIXEL = 3'($urandom);
    end
    reset = rst_next;
    if (rst_next) begin
      tm = -1;
    end else if (tm < 0) begin
      tm = 0;
      #1 check_model();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    seed      = $urandom;
    vga.PIXEL = 3'b000;
    measure   = 1'b0;
    vis_cnt   = 0;
    hs_cnt    = 0;
    vs_cnt    = 0;
    fs_first  = -1;
    fs_second = -1;

    // Reset held for 5 clocks, then released.
    repeat (4) cycle(1'b1);
    cycle(1'b0);

    // Free run over two full frames with per-frame statistics.
    measure = 1'b1;
    repeat (2 * FR + 40) cycle(1'b0);
    measure = 1'b0;
    check("visible_per_frame", 32'(vis_cnt), 32'(HV * VV));
    check("hs_per_frame",      32'(hs_cnt),  32'(HSY * VT));
    check("vs_per_frame",      32'(vs_cnt),  32'(VSY * HT));
    check("frame_period",      32'(fs_second - fs_first), 32'(FR));

    // Mid-frame reset while both syncs are asserted on the pins.
    seed  = $urandom;
    found = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      cycle(1'b0);
      if (exp_hs_on && exp_vs_on && (found || $urandom_range(0, 2) == 0)) begin
        found = 1'b1;
        break;
      end
      if (exp_hs_on && exp_vs_on) found = 1'b1;
    end
    check("midrst_sync_window", 32'(found), 1);
    check("midrst_hs_before", 32'(vga.VGA_HS), 32'(HSP));
    check("midrst_vs_before", 32'(vga.VGA_VS), 32'(VSP));
    n = $urandom_range(1, 3);
    repeat (n) cycle(1'b1);
    cycle(1'b0);
    repeat (FR + 40) cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
